conv_row_ctrl: RTL and testbench
================================

# conv_row_ctrl

Row-stationary sequencer for the convolution array inside TOP. It replaces hand-driven row control with a state machine. After one `start_conv` pulse it walks every kernel, channel and input row. For each step it drives the memory fetch strobes (`wgt_read`, `ifm_read`), the PE load strobes (`set_wgt`, `set_ifm`) and the per-kernel-row psum FIFO enables (`wr_en`, `rd_en`, `wr_clr`, `rd_clr`). It sits between the IFM/weight memories and the PE array plus psum FIFOs, all in the `clk1` domain.

## Interface
- IFM_WIDTH, 64, pixels per input row
- IFM_HEIGHT, 64, input rows per channel
- KERNEL_SIZE, 3, kernel rows/cols; also number of psum FIFOs
- NUM_CHANNEL, 3, input channels
- KERNEL_NUM, 8, output kernels
- OFM_SIZE, IFM_WIDTH-KERNEL_SIZE+1 (62), output rows/cols
- clk1  in  1  clock; one clock domain, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_conv  in  1  one-cycle start pulse; ignored while busy
- wgt_read  out  1  fetch one 72-bit 3x3 weight word
- ifm_read  out  1  fetch one IFM pixel
- set_wgt  out  1  wgt_read delayed 1 cycle; PE loads weight
- set_ifm  out  1  ifm_read delayed 1 cycle; PE loads pixel
- wr_en  out  KERNEL_SIZE  psum FIFO j write enable
- rd_en  out  KERNEL_SIZE  psum FIFO j read enable
- wr_clr  out  1  FIFO write-pointer clear pulse
- rd_clr  out  1  FIFO read-pointer clear pulse
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- row_idx  out  $clog2(IFM_HEIGHT)  current input row
- ch_idx  out  $clog2(NUM_CHANNEL)  current channel
- k_idx  out  $clog2(KERNEL_NUM)  current kernel

## Operation
- States: IDLE, WGT, ROW, GAP, DONE. Loop order is kernel k (outer), then channel c, then row r.
- IDLE: waits for `start_conv`. Counters k, c, r and col are held at 0. `start_conv` moves to WGT.
- WGT: lasts 1 cycle. `wgt_read=1`. Then ROW with r=0, col=0.
- ROW: lasts IFM_WIDTH cycles, col 0..IFM_WIDTH-1.
  - `ifm_read=1` in every ROW cycle.
  - `wr_clr=1` at col 0.
  - After col IFM_WIDTH-1, go to GAP.
- GAP: lasts 1 cycle. `rd_clr=1`. Next state:
  - r < IFM_HEIGHT-1: r++, go to ROW.
  - else c < NUM_CHANNEL-1: c++, r=0, go to WGT.
  - else k < KERNEL_NUM-1: k++, c=0, r=0, go to WGT.
  - else go to DONE.
- DONE: lasts 1 cycle. `done=1`, counters clear, go to IDLE.
- Enable decode is combinational in ROW and registered onto the ports 1 cycle later. Let win = (col >= KERNEL_SIZE-1).
  - wr_en[j] = win && 0 <= r-j <= OFM_SIZE-1
  - rd_en[j], for j < KERNEL_SIZE-1 = win && 0 <= r-1-j <= OFM_SIZE-1 (reads back the row written by stage j one row earlier)
  - rd_en[KERNEL_SIZE-1] = win && c > 0 && 0 <= r-(KERNEL_SIZE-1) <= OFM_SIZE-1 (cross-channel accumulation)
- Signals decoded from state with no delay: `ifm_read`, `wgt_read`, `wr_clr`, `rd_clr`, `busy`, `done`, and the index outputs.

## Timing
- Reset: all outputs 0; state IDLE; delay flops cleared.
- Reset mid-operation: immediate abort to IDLE with all outputs 0. No resume.
- Start latency: `start_conv` sampled at edge 0 gives `wgt_read` in cycle 1.
- Cycles per (k,c): 1 + IFM_HEIGHT*(IFM_WIDTH+1).
- `done` arrives at cycle 1 + KERNEL_NUM*NUM_CHANNEL*(1+IFM_HEIGHT*(IFM_WIDTH+1)).
- Delayed signals: for the last column of a row, `set_ifm`, `wr_en` and `rd_en` appear in the GAP cycle. No enable is ever issued in WGT or IDLE.
- `start_conv` while busy is dropped. `start_conv` in the DONE cycle is dropped.
- Back-to-back runs: a new start is accepted from IDLE the cycle after DONE.

## Configuration
- CONV_CTRL_STALL_EN defined: adds input `stall` (1 bit).
  - While `stall=1`: state and counters freeze, and `ifm_read`, `wgt_read`, `wr_clr`, `rd_clr` are forced to 0.
  - The delay flops load 0, so `set_*`, `wr_en` and `rd_en` read 0 one cycle later.
  - `busy` stays high during a stall.
- CONV_CTRL_STALL_EN not defined: no `stall` port; the sequence never pauses.

## Test plan
- Small config IFM_WIDTH=IFM_HEIGHT=5, KERNEL_SIZE=3, NUM_CHANNEL=2, KERNEL_NUM=1 (OFM_SIZE=3); start at edge 0 -> `wgt_read` in cycles 1 and 32; `done` in cycle 63 only; `busy` high cycles 1-62.
- Same config, channel 0 -> `wr_en[0]` high 3 cycles per row in rows 0-2 (9 total); `wr_en[2]` in rows 2-4; `rd_en[0]` in rows 1-3; `rd_en[2]` never.
- Same config, channel 1 -> `rd_en[2]` high 9 cycles total, coincident with `wr_en[2]`.
- Every row -> `wr_clr` coincides with col-0 `ifm_read`; `rd_clr` 1 cycle after last `ifm_read`; `set_ifm` equals `ifm_read` shifted by 1 cycle, 25 pulses per channel.
- `rst_n` dropped at cycle 20 -> all outputs 0 in the same cycle; a new start after release runs the full 63-cycle sequence.
- CONV_CTRL_STALL_EN with `stall` high for cycles 10-14 -> `done` moves to cycle 68; no strobe during the stall; `start_conv` pulse at cycle 30 ignored.

Source files
------------

// File: rtl/conv_row_ctrl_if.sv
// Control bundle between the row-stationary sequencer and the PE array / psum FIFOs.
// master: sequencer side; slave: array/memory side that issues start_conv.
interface conv_row_ctrl_if #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ROW_W       = 6,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned K_W         = 3
);
    logic                   start_conv;
    logic                   wgt_read;
    logic                   ifm_read;
    logic                   set_wgt;
    logic                   set_ifm;
    logic [KERNEL_SIZE-1:0] wr_en;
    logic [KERNEL_SIZE-1:0] rd_en;
    logic                   wr_clr;
    logic                   rd_clr;
    logic                   busy;
    logic                   done;
    logic [ROW_W-1:0]       row_idx;
    logic [CH_W-1:0]        ch_idx;
    logic [K_W-1:0]         k_idx;

    modport master (
        input  start_conv,
        output wgt_read, ifm_read, set_wgt, set_ifm, wr_en, rd_en,
        output wr_clr, rd_clr, busy, done, row_idx, ch_idx, k_idx
    );

    modport slave (
        output start_conv,
        input  wgt_read, ifm_read, set_wgt, set_ifm, wr_en, rd_en,
        input  wr_clr, rd_clr, busy, done, row_idx, ch_idx, k_idx
    );
endinterface

// File: rtl/conv_row_ctrl.sv
// Row-stationary sequencer: walks kernel > channel > row, driving fetch, PE load and psum FIFO strobes.
// Optional CONV_CTRL_STALL_EN adds a stall input that freezes the walk and blanks all strobes.
module conv_row_ctrl #(
    parameter int unsigned IFM_WIDTH   = 64,
    parameter int unsigned IFM_HEIGHT  = 64,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned NUM_CHANNEL = 3,
    parameter int unsigned KERNEL_NUM  = 8
) (
    input  logic                  clk1,
    input  logic                  rst_n,
`ifdef CONV_CTRL_STALL_EN
    input  logic                  stall,
`endif
    conv_row_ctrl_if.master       bus
);
    localparam int unsigned OFM_SIZE = IFM_WIDTH - KERNEL_SIZE + 1;
    localparam int unsigned ROW_W    = (IFM_HEIGHT  > 1) ? $clog2(IFM_HEIGHT)  : 1;
    localparam int unsigned CH_W     = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam int unsigned K_W      = (KERNEL_NUM  > 1) ? $clog2(KERNEL_NUM)  : 1;
    localparam int unsigned COL_W    = (IFM_WIDTH   > 1) ? $clog2(IFM_WIDTH)   : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IFM_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IFM_HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNEL - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(KERNEL_NUM - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWgt,
        StRow,
        StGap,
        StDone
    } state_e;

    state_e                 r_state;
    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    logic [CH_W-1:0]        r_ch;
    logic [K_W-1:0]         r_k;
    logic                   r_set_wgt;
    logic                   r_set_ifm;
    logic [KERNEL_SIZE-1:0] r_wr_en;
    logic [KERNEL_SIZE-1:0] r_rd_en;

    logic                   w_stall;
    logic                   w_wgt_read;
    logic                   w_ifm_read;
    logic                   w_wr_clr;
    logic                   w_rd_clr;
    logic                   w_win;
    logic [31:0]            w_r;
    logic [KERNEL_SIZE-1:0] w_wr_dec;
    logic [KERNEL_SIZE-1:0] w_rd_dec;

`ifdef CONV_CTRL_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_wgt_read = (r_state == StWgt) && !w_stall;
    assign w_ifm_read = (r_state == StRow) && !w_stall;
    assign w_wr_clr   = w_ifm_read && (r_col == '0);
    assign w_rd_clr   = (r_state == StGap) && !w_stall;

    assign w_win = (32'(r_col) >= KERNEL_SIZE - 1);
    assign w_r   = 32'(r_row);

    // Stage j writes output row r-j; stage j<K-1 reads back what stage j wrote one row earlier;
    // the last stage reads only from channel 1 on, to accumulate across channels.
    always_comb begin
        w_wr_dec = '0;
        w_rd_dec = '0;
        if (w_ifm_read && w_win) begin
            for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
                w_wr_dec[j] = (w_r >= j) && (w_r <= j + OFM_SIZE - 1);
                if (j < KERNEL_SIZE - 1) begin
                    w_rd_dec[j] = (w_r >= j + 1) && (w_r <= j + OFM_SIZE);
                end else begin
                    w_rd_dec[j] = (r_ch != '0) && (w_r >= j) && (w_r <= j + OFM_SIZE - 1);
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_col     <= '0;
            r_row     <= '0;
            r_ch      <= '0;
            r_k       <= '0;
            r_set_wgt <= 1'b0;
            r_set_ifm <= 1'b0;
            r_wr_en   <= '0;
            r_rd_en   <= '0;
        end else begin
            // Strobes are already gated by stall, so the delay line loads 0 while stalled.
            r_set_wgt <= w_wgt_read;
            r_set_ifm <= w_ifm_read;
            r_wr_en   <= w_wr_dec;
            r_rd_en   <= w_rd_dec;
            if (!w_stall) begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.start_conv) begin
                            r_state <= StWgt;
                        end
                    end
                    StWgt: begin
                        r_state <= StRow;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                    StRow: begin
                        if (r_col == COL_LAST) begin
                            r_state <= StGap;
                            r_col   <= '0;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                    StGap: begin
                        if (r_row != ROW_LAST) begin
                            r_row   <= r_row + ROW_W'(1);
                            r_state <= StRow;
                        end else if (r_ch != CH_LAST) begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_row   <= '0;
                            r_state <= StWgt;
                        end else if (r_k != K_LAST) begin
                            r_k     <= r_k + K_W'(1);
                            r_ch    <= '0;
                            r_row   <= '0;
                            r_state <= StWgt;
                        end else begin
                            r_row   <= '0;
                            r_ch    <= '0;
                            r_k     <= '0;
                            r_state <= StDone;
                        end
                    end
                    StDone: begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_ch    <= '0;
                        r_k     <= '0;
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.wgt_read = w_wgt_read;
    assign bus.ifm_read = w_ifm_read;
    assign bus.wr_clr   = w_wr_clr;
    assign bus.rd_clr   = w_rd_clr;
    assign bus.set_wgt  = r_set_wgt;
    assign bus.set_ifm  = r_set_ifm;
    assign bus.wr_en    = r_wr_en;
    assign bus.rd_en    = r_rd_en;
    assign bus.busy     = (r_state == StWgt) || (r_state == StRow) || (r_state == StGap);
    assign bus.done     = (r_state == StDone);
    assign bus.row_idx  = r_row;
    assign bus.ch_idx   = r_ch;
    assign bus.k_idx    = r_k;

endmodule

// File: tb/tb_conv_row_ctrl.sv
// Scoreboard bench for conv_row_ctrl on a 5x5 / 3x3 / 2-channel / 1-kernel configuration.
// Expected per-cycle outputs come from a nested-loop trace generator; stall cases under CONV_CTRL_STALL_EN.
module tb_conv_row_ctrl;
    localparam int W   = 5;
    localparam int H   = 5;
    localparam int KS  = 3;
    localparam int NC  = 2;
    localparam int KN  = 1;
    localparam int OFM = W - KS + 1;
    localparam int RW  = (H  > 1) ? $clog2(H)  : 1;
    localparam int CW  = (NC > 1) ? $clog2(NC) : 1;
    localparam int KW  = (KN > 1) ? $clog2(KN) : 1;
    localparam int RUN = 1 + KN * NC * (1 + H * (W + 1));
`ifdef CONV_CTRL_STALL_EN
    localparam int STALL_LO = 10;
    localparam int STALL_HI = 14;
`else
    localparam int STALL_LO = 0;
    localparam int STALL_HI = -1;
`endif
    localparam int D = RUN + (STALL_HI - STALL_LO + 1);

    typedef struct packed {
        logic          wgt_read;
        logic          ifm_read;
        logic          set_wgt;
        logic          set_ifm;
        logic [KS-1:0] wr_en;
        logic [KS-1:0] rd_en;
        logic          wr_clr;
        logic          rd_clr;
        logic          busy;
        logic          done;
        logic [RW-1:0] row;
        logic [CW-1:0] ch;
        logic [KW-1:0] k;
    } obs_t;

    typedef struct packed {
        obs_t          o;
        logic          sw;
        logic          si;
        logic [KS-1:0] we;
        logic [KS-1:0] re;
    } step_t;

    logic clk1;
    logic rst_n;
`ifdef CONV_CTRL_STALL_EN
    logic stall_drv;
`endif

    conv_row_ctrl_if #(.KERNEL_SIZE(KS), .ROW_W(RW), .CH_W(CW), .K_W(KW)) bus_if ();

    conv_row_ctrl #(
        .IFM_WIDTH   (W),
        .IFM_HEIGHT  (H),
        .KERNEL_SIZE (KS),
        .NUM_CHANNEL (NC),
        .KERNEL_NUM  (KN)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
`ifdef CONV_CTRL_STALL_EN
        .stall (stall_drv),
`endif
        .bus   (bus_if)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    step_t steps[$];
    obs_t  exp_q[$];
    int    errs = 0;
    int    checks = 0;
    int    cyc = 0;
    int    done_first = -1;
    int    stat_base = -1;
    int    wgt_total, wgt_hit, busy_cnt, done_cnt, done_rt;
    int    wr0_c0, wr2_c0, rd0_c0, rd2_c0, rd2_c1, rd2_wr2_c1, si_c0, si_c1;
    int    wrclr_cnt, wrclr_bad, rdclr_cnt, rdclr_after;
    logic  prev_ifm;

    function automatic void gen_steps();
        step_t s;
        int o_w;
        int o_r;
        steps.delete();
        for (int k = 0; k < KN; k++) begin
            for (int c = 0; c < NC; c++) begin
                s = '0;
                s.o.wgt_read = 1'b1;
                s.o.busy = 1'b1;
                s.o.ch = CW'(c);
                s.o.k = KW'(k);
                s.sw = 1'b1;
                steps.push_back(s);
                for (int r = 0; r < H; r++) begin
                    for (int col = 0; col < W; col++) begin
                        s = '0;
                        s.o.ifm_read = 1'b1;
                        s.o.busy = 1'b1;
                        s.o.wr_clr = (col == 0);
                        s.o.row = RW'(r);
                        s.o.ch = CW'(c);
                        s.o.k = KW'(k);
                        s.si = 1'b1;
                        if (col >= KS - 1) begin
                            for (int j = 0; j < KS; j++) begin
                                o_w = r - j;
                                o_r = r - 1 - j;
                                s.we[j] = (o_w >= 0) && (o_w < OFM);
                                if (j < KS - 1) s.re[j] = (o_r >= 0) && (o_r < OFM);
                                else s.re[j] = (c > 0) && (o_w >= 0) && (o_w < OFM);
                            end
                        end
                        steps.push_back(s);
                    end
                    s = '0;
                    s.o.rd_clr = 1'b1;
                    s.o.busy = 1'b1;
                    s.o.row = RW'(r);
                    s.o.ch = CW'(c);
                    s.o.k = KW'(k);
                    steps.push_back(s);
                end
            end
        end
        s = '0;
        s.o.done = 1'b1;
        steps.push_back(s);
    endfunction

    // Expand the step list in time: stalled cycles repeat the step with strobes blanked.
    function automatic void push_run(input int st_lo, input int st_hi, input int max_cyc);
        obs_t e;
        logic sw = 1'b0;
        logic si = 1'b0;
        logic [KS-1:0] we = '0;
        logic [KS-1:0] re = '0;
        int idx = 0;
        int t = 1;
        while (idx < steps.size() && t <= max_cyc) begin
            e = steps[idx].o;
            e.set_wgt = sw;
            e.set_ifm = si;
            e.wr_en = we;
            e.rd_en = re;
            if (t >= st_lo && t <= st_hi) begin
                e.wgt_read = 1'b0;
                e.ifm_read = 1'b0;
                e.wr_clr = 1'b0;
                e.rd_clr = 1'b0;
                sw = 1'b0;
                si = 1'b0;
                we = '0;
                re = '0;
            end else begin
                sw = steps[idx].sw;
                si = steps[idx].si;
                we = steps[idx].we;
                re = steps[idx].re;
                idx++;
            end
            exp_q.push_back(e);
            t++;
        end
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('0);
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.wgt_read = bus_if.wgt_read;
        o.ifm_read = bus_if.ifm_read;
        o.set_wgt  = bus_if.set_wgt;
        o.set_ifm  = bus_if.set_ifm;
        o.wr_en    = bus_if.wr_en;
        o.rd_en    = bus_if.rd_en;
        o.wr_clr   = bus_if.wr_clr;
        o.rd_clr   = bus_if.rd_clr;
        o.busy     = bus_if.busy;
        o.done     = bus_if.done;
        o.row      = bus_if.row_idx;
        o.ch       = bus_if.ch_idx;
        o.k        = bus_if.k_idx;
        return o;
    endfunction

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic collect(input obs_t o);
        int rt;
        logic c1;
        rt = cyc - stat_base;
        if (rt >= 1 && rt <= 62) begin
            c1 = (rt >= 32);
            if (o.wgt_read) begin
                wgt_total++;
                if (rt == 1 || rt == 32) wgt_hit++;
            end
            if (o.busy) busy_cnt++;
            if (!c1 && o.wr_en[0]) wr0_c0++;
            if (!c1 && o.wr_en[2]) wr2_c0++;
            if (!c1 && o.rd_en[0]) rd0_c0++;
            if (!c1 && o.rd_en[2]) rd2_c0++;
            if (c1 && o.rd_en[2]) rd2_c1++;
            if (c1 && o.rd_en[2] && o.wr_en[2]) rd2_wr2_c1++;
            if (!c1 && o.set_ifm) si_c0++;
            if (c1 && o.set_ifm) si_c1++;
            if (o.wr_clr) wrclr_cnt++;
            if (o.wr_clr && !o.ifm_read) wrclr_bad++;
            if (o.rd_clr) rdclr_cnt++;
            if (o.rd_clr && prev_ifm) rdclr_after++;
        end
        if (rt >= 1 && rt <= 70 && o.done) begin
            done_cnt++;
            if (done_rt < 0) done_rt = rt;
        end
        prev_ifm = o.ifm_read;
    endtask

    // One clock: drive inputs just after the rising edge, compare on the falling edge.
    task automatic step(input logic st, input logic sl, input logic rn);
        obs_t o;
        obs_t e;
        @(posedge clk1);
        #1;
        bus_if.start_conv = st;
        rst_n = rn;
`ifdef CONV_CTRL_STALL_EN
        stall_drv = sl;
`else
        if (sl) $error("FAIL stall_drive got=1 want=0 (no stall port in this build)");
`endif
        @(negedge clk1);
        o = sample();
        checks++;
        if (exp_q.size() == 0) begin
            errs++;
            $error("FAIL scoreboard_empty cyc=%0d got=%h want=<entry>", cyc, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                errs++;
                $error("FAIL trace cyc=%0d got=%h want=%h", cyc, o, e);
            end
        end
        if (o.done && done_first < 0) done_first = cyc;
        if (stat_base >= 0) collect(o);
        cyc++;
    endtask

    initial begin
        obs_t o;
        rst_n = 1'b0;
        bus_if.start_conv = 1'b1;
`ifdef CONV_CTRL_STALL_EN
        stall_drv = 1'b0;
`endif
        gen_steps();
        #2;
        o = sample();
        chk("reset_async_outputs", int'(o), 0);

        // Reset held with start high: nothing moves.
        push_idle(3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Run A (stall window in stall build), start in busy and DONE dropped, then back-to-back run B.
        exp_q.delete();
        push_idle(1);
        push_run(STALL_LO, STALL_HI, 1000000);
        push_idle(1);
        push_run(0, -1, 1000000);
        push_idle(2);
        cyc = 0;
        done_first = -1;
        stat_base = D + 1;
        wgt_total = 0; wgt_hit = 0; busy_cnt = 0; done_cnt = 0; done_rt = -1;
        wr0_c0 = 0; wr2_c0 = 0; rd0_c0 = 0; rd2_c0 = 0; rd2_c1 = 0; rd2_wr2_c1 = 0;
        si_c0 = 0; si_c1 = 0; wrclr_cnt = 0; wrclr_bad = 0; rdclr_cnt = 0; rdclr_after = 0;
        prev_ifm = 1'b0;
        for (int t = 0; t <= D + 66; t++) begin
            step((t == 0) || (t == 30) || (t == D) || (t == D + 1),
                 (t >= STALL_LO) && (t <= STALL_HI), 1'b1);
        end
        stat_base = -1;
        chk("run_a_done_cycle", done_first, D);
        chk("run_b_done_cycle", done_rt, 63);
        chk("run_b_done_count", done_cnt, 1);
        chk("run_b_busy_cycles", busy_cnt, 62);
        chk("run_b_wgt_total", wgt_total, 2);
        chk("run_b_wgt_at_1_32", wgt_hit, 2);
        chk("c0_wr_en0", wr0_c0, 9);
        chk("c0_wr_en2", wr2_c0, 9);
        chk("c0_rd_en0", rd0_c0, 9);
        chk("c0_rd_en2", rd2_c0, 0);
        chk("c1_rd_en2", rd2_c1, 9);
        chk("c1_rd_en2_with_wr_en2", rd2_wr2_c1, 9);
        chk("c0_set_ifm", si_c0, 25);
        chk("c1_set_ifm", si_c1, 25);
        chk("wr_clr_count", wrclr_cnt, 10);
        chk("wr_clr_without_ifm", wrclr_bad, 0);
        chk("rd_clr_count", rdclr_cnt, 10);
        chk("rd_clr_after_ifm", rdclr_after, 10);

        // Reset mid-run at cycle 20, restart after release.
        exp_q.delete();
        push_idle(1);
        push_run(0, -1, 19);
        push_idle(4);
        push_run(0, -1, 1000000);
        push_idle(2);
        cyc = 0;
        done_first = -1;
        for (int t = 0; t <= 88; t++) begin
            step((t == 0) || (t == 23), 1'b0, !((t == 20) || (t == 21)));
        end
        chk("restart_done_cycle", done_first, 86);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
